// File: rtl/serial_frame_rx_if.sv
// Serial bit input and decoded frame outputs of serial_frame_rx.
// The receiver takes the slave view; the bit source takes the master view.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 4
);
    logic              in;
    logic              in_valid;
    logic              sync_found;
    logic              addr_match;
    logic [DATA_W-1:0] data_out;
    logic [CRC_W-1:0]  crc_out;
    logic              data_valid;
    logic              crc_err;
    logic              busy;

    modport master (
        output in, in_valid,
        input  sync_found, addr_match, data_out, crc_out, data_valid, crc_err, busy
    );

    modport slave (
        input  in, in_valid,
        output sync_found, addr_match, data_out, crc_out, data_valid, crc_err, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, address match, payload capture with
// serial CRC, and optional check of a trailing CRC field.
module serial_frame_rx #(
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1011,
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] MY_ADDR   = 4'hA,
    parameter int                DATA_W    = 8,
    parameter int                CRC_W     = 4,
    parameter logic [CRC_W-1:0]  CRC_POLY  = 4'h3,
    parameter logic [CRC_W-1:0]  CRC_INIT  = 4'h0,
    parameter bit                CHECK_CRC = 1'b1
) (
    input logic               clk,
    input logic               rst,
    serial_frame_rx_if.slave  bus
);
    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_W  = (MAX_AD > CRC_W) ? MAX_AD : CRC_W;
    localparam int CNT_W  = $clog2(MAX_W + 1);
    localparam int FILL_W = $clog2(SYNC_W + 1);

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CRC_LAST  = CNT_W'(CRC_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);

    generate
        if (SYNC_W < 1 || ADDR_W < 1 || DATA_W < 1 || CRC_W < 1) begin : g_bad_width
            $error("serial_frame_rx: every width parameter must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {HUNT, ADDR, DATA, RXCRC} state_t;

    state_t              state, state_nxt;
    logic [SYNC_W-1:0]   win, win_nxt;
    logic [FILL_W-1:0]   fill, fill_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_sh, addr_sh_nxt;
    logic [DATA_W-1:0]   data_sh, data_sh_nxt;
    logic [CRC_W-1:0]    crc, crc_nxt;
    logic [CRC_W-1:0]    rx_crc, rx_crc_nxt;

    logic                sync_q, sync_nxt;
    logic                amatch_q, amatch_nxt;
    logic                dv_q, dv_nxt;
    logic                err_q, err_nxt;
    logic [DATA_W-1:0]   dout_q, dout_nxt;
    logic [CRC_W-1:0]    cout_q, cout_nxt;

    // Each shift register with the incoming bit appended at the LSB (MSB-first wire order).
    logic [SYNC_W:0]     win_ext;
    logic [ADDR_W:0]     addr_ext;
    logic [DATA_W:0]     data_ext;
    logic [CRC_W:0]      rx_ext;
    logic [CRC_W:0]      crc_ext;
    logic [SYNC_W-1:0]   win_sh;
    logic [ADDR_W-1:0]   addr_shift;
    logic [DATA_W-1:0]   data_shift;
    logic [CRC_W-1:0]    rx_shift;
    logic [CRC_W-1:0]    crc_step;
    logic [FILL_W-1:0]   fill_inc;

    assign win_ext    = {win, bus.in};
    assign addr_ext   = {addr_sh, bus.in};
    assign data_ext   = {data_sh, bus.in};
    assign rx_ext     = {rx_crc, bus.in};
    assign crc_ext    = {crc, 1'b0};
    assign win_sh     = win_ext[SYNC_W-1:0];
    assign addr_shift = addr_ext[ADDR_W-1:0];
    assign data_shift = data_ext[DATA_W-1:0];
    assign rx_shift   = rx_ext[CRC_W-1:0];
    assign crc_step   = crc_ext[CRC_W-1:0] ^ ((crc[CRC_W-1] ^ bus.in) ? CRC_POLY : '0);
    assign fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            win      <= '0;
            fill     <= '0;
            cnt      <= '0;
            addr_sh  <= '0;
            data_sh  <= '0;
            crc      <= CRC_INIT;
            rx_crc   <= '0;
            sync_q   <= 1'b0;
            amatch_q <= 1'b0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
            cout_q   <= '0;
        end else begin
            state    <= state_nxt;
            win      <= win_nxt;
            fill     <= fill_nxt;
            cnt      <= cnt_nxt;
            addr_sh  <= addr_sh_nxt;
            data_sh  <= data_sh_nxt;
            crc      <= crc_nxt;
            rx_crc   <= rx_crc_nxt;
            sync_q   <= sync_nxt;
            amatch_q <= amatch_nxt;
            dv_q     <= dv_nxt;
            err_q    <= err_nxt;
            dout_q   <= dout_nxt;
            cout_q   <= cout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        win_nxt     = win;
        fill_nxt    = fill;
        cnt_nxt     = cnt;
        addr_sh_nxt = addr_sh;
        data_sh_nxt = data_sh;
        crc_nxt     = crc;
        rx_crc_nxt  = rx_crc;
        sync_nxt    = 1'b0;
        amatch_nxt  = 1'b0;
        dv_nxt      = 1'b0;
        err_nxt     = 1'b0;
        dout_nxt    = dout_q;
        cout_nxt    = cout_q;

        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    win_nxt  = win_sh;
                    fill_nxt = fill_inc;
                    // Only a completely filled window may match, so no false sync out of reset.
                    if (fill_inc == FILL_FULL && win_sh == SYNC_PAT) begin
                        sync_nxt  = 1'b1;
                        state_nxt = ADDR;
                        cnt_nxt   = '0;
                    end
                end
                ADDR: begin
                    addr_sh_nxt = addr_shift;
                    cnt_nxt     = cnt + CNT_W'(1);
                    if (cnt == ADDR_LAST) begin
                        cnt_nxt = '0;
                        if (addr_shift == MY_ADDR) begin
                            amatch_nxt = 1'b1;
                            state_nxt  = DATA;
                            crc_nxt    = CRC_INIT;
                        end else begin
                            state_nxt = HUNT;
                            win_nxt   = '0;
                            fill_nxt  = '0;
                        end
                    end
                end
                DATA: begin
                    data_sh_nxt = data_shift;
                    crc_nxt     = crc_step;
                    cnt_nxt     = cnt + CNT_W'(1);
                    if (cnt == DATA_LAST) begin
                        cnt_nxt = '0;
                        if (CHECK_CRC) begin
                            state_nxt = RXCRC;
                        end else begin
                            dout_nxt  = data_shift;
                            cout_nxt  = crc_step;
                            dv_nxt    = 1'b1;
                            state_nxt = HUNT;
                            win_nxt   = '0;
                            fill_nxt  = '0;
                        end
                    end
                end
                RXCRC: begin
                    rx_crc_nxt = rx_shift;
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (cnt == CRC_LAST) begin
                        cnt_nxt  = '0;
                        cout_nxt = crc;
                        // A bad CRC still reports the computed value but keeps the last good payload.
                        if (rx_shift == crc) begin
                            dout_nxt = data_sh;
                            dv_nxt   = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        state_nxt = HUNT;
                        win_nxt   = '0;
                        fill_nxt  = '0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign bus.sync_found = sync_q;
    assign bus.addr_match = amatch_q;
    assign bus.data_valid = dv_q;
    assign bus.crc_err    = err_q;
    assign bus.data_out   = dout_q;
    assign bus.crc_out    = cout_q;
    assign bus.busy       = (state != HUNT);
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Parametrised serial frame receiver, next generation of the sync-detect / address / data-capture / CRC chain.
- Hunts a serial bit stream for a configurable sync pattern, then matches a node address.
- Captures a DATA_W-bit payload while computing a serial CRC.
- Optionally checks a trailing received CRC field.
- Runs in a single clock domain, so there is no separate CRC clock. Bits arrive qualified by a valid strobe.

Parameters:
SYNC_W, 4, sync pattern width
SYNC_PAT, 4'b1011, sync pattern, MSB first on the wire
ADDR_W, 4, address field width
MY_ADDR, 4'hA, address this node accepts
DATA_W, 8, payload width
CRC_W, 4, CRC width
CRC_POLY, 4'h3, generator polynomial without the implicit top bit (x^4+x+1)
CRC_INIT, 4'h0, CRC preset at the start of each payload
CHECK_CRC, 1, 1 = frame carries a CRC_W-bit CRC after the payload, which is checked; 0 = no CRC field, CRC is computed and reported only

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
in  in  1  serial data bit
in_valid  in  1  qualifies `in`; one bit is consumed per clk with in_valid=1
sync_found  out  1  1-cycle pulse when the sync pattern is accepted
addr_match  out  1  1-cycle pulse when the address field equals MY_ADDR
data_out  out  DATA_W  last good payload, held until the next good frame
crc_out  out  CRC_W  CRC computed over the last completed payload
data_valid  out  1  1-cycle pulse when data_out/crc_out update
crc_err  out  1  1-cycle pulse on CRC mismatch (CHECK_CRC=1 only)
busy  out  1  1 whenever the state is not HUNT

Behaviour:
- Reset (async, rst=1): state HUNT; shift/fill/bit counters = 0; CRC = CRC_INIT; all outputs = 0.
- Bit order: every field is sent MSB first.
- Bit consumption: state, counters, shift registers and CRC advance only on cycles with in_valid=1. With in_valid=0 everything holds and every pulse output is 0.
- HUNT:
  - Sliding SYNC_W-bit window; fill counter saturates at SYNC_W.
  - Match is legal only when fill = SYNC_W, so an all-zero pattern cannot false-trigger out of reset. Overlapping patterns are found naturally.
  - On the edge accepting the matching bit: sync_found=1 next cycle; go to ADDR; bit counter=0.
- ADDR:
  - Shift in ADDR_W bits.
  - On the last bit, if address == MY_ADDR: addr_match pulse, go to DATA, CRC=CRC_INIT.
  - On the last bit, if address differs: go to HUNT with window and fill cleared.
- DATA:
  - Shift in DATA_W bits. Per bit: fb = crc[CRC_W-1]^in; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
  - Last bit with CHECK_CRC=0: load data_out and crc_out, pulse data_valid, go to HUNT.
  - Last bit with CHECK_CRC=1: go to RXCRC.
- RXCRC:
  - Shift in CRC_W bits.
  - On the last bit, if received == computed: load data_out and crc_out, pulse data_valid.
  - On the last bit, if they differ: pulse crc_err; crc_out updates; data_out holds its old value.
  - Go to HUNT in both cases.
- Returning to HUNT always clears the window and fill counter. A new frame may begin on the very next valid bit, so back-to-back frames have zero gap.
- Latency: pulses assert in the cycle after the clock edge that consumed the deciding bit.
- Counter width: clog2(max(ADDR_W, DATA_W, CRC_W)+1).
- Width rules:
  - SYNC_PAT is compared across its full SYNC_W bits.
  - CRC arithmetic is modulo 2^CRC_W.
  - Elaboration error if any width parameter is < 1.
- Reset mid-frame aborts the frame: no pulses, and data_out is cleared to 0.

Test Plan:
- Defaults, continuous in_valid, stream 1011 1010 10100101 1011 -> sync_found after bit 4, addr_match after bit 8, data_valid after bit 20 with data_out=8'hA5, crc_out=4'hB, crc_err=0.
- Same frame with CRC field 1010 -> crc_err pulse, data_valid=0, data_out keeps its prior value (0 after reset), crc_out=4'hB.
- Address 0110 after sync -> no addr_match, busy drops. The following 1011 1010 10100101 1011 decodes to data_out=8'hA5.
- Overlap: bits 1,0,1,0,1,1 -> sync_found exactly once, after bit 6.
- Repeat the first scenario with in_valid=0 on alternate cycles -> identical outputs; pulses occur only after valid bits; no pulses during the gaps.
- Assert rst for 1 cycle midway through DATA -> all outputs 0 and state HUNT. The next full good frame yields data_valid with data_out=8'hA5. Also run CHECK_CRC=0 with the CRC field omitted -> data_valid after bit 16.
